pipe_addsub32: RTL and testbench

- Two-stage pipelined 32-bit adder/subtractor with valid/ready handshakes on input and output.
- Used as the registered arithmetic unit for multicycle or retimed ALU paths in the MIPS pipeline.
- Subtraction is computed as din1 + ~din2 + 1.
- The low half is computed in stage 1; the registered carry feeds the high half in stage 2, breaking the 32-bit carry chain across a register.
- Reports carry/borrow, signed overflow and zero flags.

---
 rtl/pipe_addsub32_pkg.sv | 6 +
 rtl/pipe_addsub32_if.sv | 28 ++
 rtl/pipe_addsub32_csa.sv | 28 ++
 rtl/pipe_addsub32.sv | 121 ++++++++++++
 tb/tb_pipe_addsub32.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_addsub32_pkg.sv
// Shared ALU constants: datapath width and the add/subtract op encoding.
package pipe_addsub32_pkg;
  localparam int   ALU_WIDTH = 32;
  localparam logic OP_ADD    = 1'b0;
  localparam logic OP_SUB    = 1'b1;
endpackage

// File: rtl/pipe_addsub32_if.sv
// Operand/result handshake bundle for the pipelined adder/subtractor.
interface pipe_addsub32_if
  import pipe_addsub32_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] din1;
  logic [WIDTH-1:0] din2;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, din1, din2, op_sub, out_ready,
    input  in_ready, out_valid, dout, carry_out, overflow, zero
  );

  modport slave (
    input  in_valid, din1, din2, op_sub, out_ready,
    output in_ready, out_valid, dout, carry_out, overflow, zero
  );
endinterface

// File: rtl/pipe_addsub32_csa.sv
// Carry-select adder: lower part ripples, upper part is precomputed for both
// carries and selected by the lower carry.
module csa16_nov #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  localparam int LW = WIDTH / 2;
  localparam int UW = WIDTH - LW;

  logic [LW:0] lo;
  logic [UW:0] hi0;
  logic [UW:0] hi1;
  logic [UW:0] hi;

  always_comb begin
    lo        = {1'b0, a[LW-1:0]} + {1'b0, b[LW-1:0]} + (LW+1)'(carry_in);
    hi0       = {1'b0, a[WIDTH-1:LW]} + {1'b0, b[WIDTH-1:LW]};
    hi1       = {1'b0, a[WIDTH-1:LW]} + {1'b0, b[WIDTH-1:LW]} + (UW+1)'(1);
    hi        = lo[LW] ? hi1 : hi0;
    sum       = {hi[UW-1:0], lo[LW-1:0]};
    carry_out = hi[UW];
  end
endmodule

// File: rtl/pipe_addsub32.sv
// Two-stage add/sub: low half in stage 1, registered carry feeds the high half
// in stage 2, so the full carry chain never spans one cycle.
module pipe_addsub32
  import pipe_addsub32_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  pipe_addsub32_if.slave bus
);
  localparam int HALF = WIDTH / 2;

  function automatic logic ovf_calc(input logic sub, input logic a_msb,
                                    input logic b_msb, input logic r_msb);
    if (sub == OP_ADD) return (a_msb == b_msb) && (r_msb != a_msb);
    else               return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

  function automatic logic is_zero(input logic [WIDTH-1:0] v);
    return v == '0;
  endfunction

  logic             vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic             s2_free, adv_p1, accept;
  logic [WIDTH-1:0] b_full;
  logic [HALF-1:0]  lo_sum_new, hi_sum;
  logic             lo_c_new, hi_c;
  logic [HALF-1:0]  lo_sum_p1_q, lo_sum_p1_d, hi_a_p1_q, hi_a_p1_d, hi_b_p1_q, hi_b_p1_d;
  logic             lo_c_p1_q, lo_c_p1_d, a_msb_p1_q, a_msb_p1_d;
  logic             b_msb_p1_q, b_msb_p1_d, sub_p1_q, sub_p1_d;
  logic [WIDTH-1:0] dout_p2_q, dout_p2_d, res;
  logic             carry_p2_q, carry_p2_d, ovf_p2_q, ovf_p2_d, zero_p2_q, zero_p2_d;

  assign b_full = (bus.op_sub == OP_SUB) ? ~bus.din2 : bus.din2;

  csa16_nov #(.WIDTH(HALF)) u_lo (
    .a(bus.din1[HALF-1:0]), .b(b_full[HALF-1:0]), .carry_in(bus.op_sub),
    .sum(lo_sum_new), .carry_out(lo_c_new)
  );

  csa16_nov #(.WIDTH(HALF)) u_hi (
    .a(hi_a_p1_q), .b(hi_b_p1_q), .carry_in(lo_c_p1_q),
    .sum(hi_sum), .carry_out(hi_c)
  );

  always_comb begin
    s2_free  = !vld_p2_q || bus.out_ready;
    adv_p1   = vld_p1_q && s2_free;
    accept   = bus.in_valid && (!vld_p1_q || s2_free);
    res      = {hi_sum, lo_sum_p1_q};
    vld_p1_d = accept ? 1'b1 : (adv_p1 ? 1'b0 : vld_p1_q);
    vld_p2_d = adv_p1 ? 1'b1 : (bus.out_ready ? 1'b0 : vld_p2_q);

    // Stage 1: low-half add plus operand capture for the high half
    lo_sum_p1_d = lo_sum_p1_q;
    lo_c_p1_d   = lo_c_p1_q;
    hi_a_p1_d   = hi_a_p1_q;
    hi_b_p1_d   = hi_b_p1_q;
    a_msb_p1_d  = a_msb_p1_q;
    b_msb_p1_d  = b_msb_p1_q;
    sub_p1_d    = sub_p1_q;
    if (accept) begin
      lo_sum_p1_d = lo_sum_new;
      lo_c_p1_d   = lo_c_new;
      hi_a_p1_d   = bus.din1[WIDTH-1:HALF];
      hi_b_p1_d   = b_full[WIDTH-1:HALF];
      a_msb_p1_d  = bus.din1[WIDTH-1];
      b_msb_p1_d  = bus.din2[WIDTH-1];
      sub_p1_d    = bus.op_sub;
    end

    // Stage 2: high-half add and flag generation; held while stalled
    dout_p2_d  = dout_p2_q;
    carry_p2_d = carry_p2_q;
    ovf_p2_d   = ovf_p2_q;
    zero_p2_d  = zero_p2_q;
    if (adv_p1) begin
      dout_p2_d  = res;
      carry_p2_d = hi_c;
      ovf_p2_d   = ovf_calc(sub_p1_q, a_msb_p1_q, b_msb_p1_q, res[WIDTH-1]);
      zero_p2_d  = is_zero(res);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      dout_p2_q  <= '0;
      carry_p2_q <= 1'b0;
      ovf_p2_q   <= 1'b0;
      zero_p2_q  <= 1'b0;
    end else begin
      vld_p1_q   <= vld_p1_d;
      vld_p2_q   <= vld_p2_d;
      dout_p2_q  <= dout_p2_d;
      carry_p2_q <= carry_p2_d;
      ovf_p2_q   <= ovf_p2_d;
      zero_p2_q  <= zero_p2_d;
    end
  end

  // Stage-1 payload is qualified by vld_p1_q, so it needs no reset
  always_ff @(posedge clk) begin
    lo_sum_p1_q <= lo_sum_p1_d;
    lo_c_p1_q   <= lo_c_p1_d;
    hi_a_p1_q   <= hi_a_p1_d;
    hi_b_p1_q   <= hi_b_p1_d;
    a_msb_p1_q  <= a_msb_p1_d;
    b_msb_p1_q  <= b_msb_p1_d;
    sub_p1_q    <= sub_p1_d;
  end

  assign bus.in_ready  = !vld_p1_q || s2_free;
  assign bus.out_valid = vld_p2_q;
  assign bus.dout      = dout_p2_q;
  assign bus.carry_out = carry_p2_q;
  assign bus.overflow  = ovf_p2_q;
  assign bus.zero      = zero_p2_q;
endmodule

// File: tb/tb_pipe_addsub32.sv
// Scoreboard bench for pipe_addsub32: directed corners, backpressure, random
// handshakes and asynchronous reset mid-stream.
module tb_pipe_addsub32;
  typedef struct packed {
    logic [31:0] d;
    logic        c;
    logic        ov;
    logic        z;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   n_out = 0;
  bit   rnd_on = 1'b0;
  exp_t sb[$];

  always #5 clk = ~clk;

  pipe_addsub32_if #(.WIDTH(32)) bus ();

  pipe_addsub32 #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic exp_t mk(input logic [31:0] d, input logic c, input logic ov, input logic z);
    exp_t e;
    e.d = d; e.c = c; e.ov = ov; e.z = z;
    return e;
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic [32:0] s;
    longint      sr;
    exp_t        e;
    if (sub) begin
      s    = {1'b0, a} - {1'b0, b};
      e.c  = ~s[32];
      sr   = longint'($signed(a)) - longint'($signed(b));
    end else begin
      s    = {1'b0, a} + {1'b0, b};
      e.c  = s[32];
      sr   = longint'($signed(a)) + longint'($signed(b));
    end
    e.d  = s[31:0];
    e.ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.z  = (s[31:0] == 32'd0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one op and holds it until accepted; expectation queued on accept.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub, input exp_t e);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    bus.din1 = a; bus.din2 = b; bus.op_sub = sub; bus.in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        sb.push_back(e);
        done = 1'b1;
      end
      tick();
      n++;
      if (!done && n > 200) begin
        tests++; fails++;
        $display("FAIL send_timeout: in_ready low for %0d cycles, required accept", n);
        done = 1'b1;
      end
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    tick();
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] d0, a, b;
    logic        s;
    int          n0;

    bus.in_valid = 1'b0; bus.din1 = '0; bus.din2 = '0; bus.op_sub = 1'b0; bus.out_ready = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (!rst && bus.out_valid && bus.out_ready) begin
          exp_t act, e;
          act = mk(bus.dout, bus.carry_out, bus.overflow, bus.zero);
          n_out++;
          if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_out: got %h required no result", act);
          end else begin
            e = sb.pop_front();
            chk("result", 64'(act), 64'(e));
          end
        end
      end
      forever begin
        tick();
        if (rnd_on) bus.out_ready = 1'($urandom_range(0, 1));
      end
    join_none

    // Reset state
    repeat (2) tick();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_dout_flags", 64'({bus.dout, bus.carry_out, bus.overflow, bus.zero}), 64'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 64'(bus.in_ready), 64'd1);

    // Subtract, no stall, with latency check
    bus.out_ready = 1'b1;
    tick();
    send(32'h5, 32'h3, 1'b1, mk(32'h2, 1'b1, 1'b0, 1'b0));
    idle();
    chk("lat_cycle1_invalid", 64'(bus.out_valid), 64'd0);
    tick();
    chk("lat_cycle2_valid", 64'(bus.out_valid), 64'd1);
    chk("lat_cycle2_dout", 64'(bus.dout), 64'h2);
    drain();

    // Cross-half carry then zero, back to back
    send(32'h0000_FFFF, 32'h1, 1'b0, mk(32'h0001_0000, 1'b0, 1'b0, 1'b0));
    send(32'h1234_5678, 32'h1234_5678, 1'b1, mk(32'h0, 1'b1, 1'b0, 1'b1));
    idle();
    chk("b2b_first", 64'(bus.dout), 64'h0001_0000);
    tick();
    chk("b2b_second", 64'({bus.out_valid, bus.dout, bus.zero}), 64'({1'b1, 32'h0, 1'b1}));
    drain();

    // Overflow / borrow corners
    send(32'h7FFF_FFFF, 32'h1, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0));
    send(32'h8000_0000, 32'h1, 1'b1, mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
    send(32'h0, 32'h1, 1'b1, mk(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0));
    send(32'hFFFF_FFFF, 32'h1, 1'b0, mk(32'h0, 1'b1, 1'b0, 1'b1));
    send(32'h8000_0000, 32'h8000_0000, 1'b0, mk(32'h0, 1'b1, 1'b1, 1'b1));
    send(32'h0, 32'h8000_0000, 1'b1, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0));
    idle();
    drain();

    // Backpressure: two items buffered, then release
    bus.out_ready = 1'b0;
    n0 = n_out;
    send(32'h1, 32'h2, 1'b0, mk(32'h3, 1'b0, 1'b0, 1'b0));
    send(32'hA, 32'h4, 1'b1, mk(32'h6, 1'b1, 1'b0, 1'b0));
    bus.din1 = 32'h100; bus.din2 = 32'h200; bus.op_sub = 1'b0; bus.in_valid = 1'b1;
    #1;
    chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
    d0 = bus.dout;
    repeat (3) begin
      tick();
      chk("bp_hold", 64'({bus.out_valid, bus.in_ready, bus.dout}), 64'({1'b1, 1'b0, d0}));
    end
    bus.out_ready = 1'b1;
    send(32'h100, 32'h200, 1'b0, mk(32'h300, 1'b0, 1'b0, 1'b0));
    send(32'hFFFF_0000, 32'h0001_0000, 1'b0, mk(32'h0, 1'b1, 1'b0, 1'b1));
    idle();
    drain();
    chk("bp_count", 64'(n_out - n0), 64'd4);

    // Random operands with random handshakes
    rnd_on = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      idle();
      repeat ($urandom_range(0, 2)) tick();
      case ($urandom_range(0, 3))
        0:       a = 32'h8000_0000;
        1:       a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 5) == 0) ? a : $urandom;
      s = 1'($urandom_range(0, 1));
      send(a, b, s, model(a, b, s));
    end
    idle();
    rnd_on = 1'b0;
    repeat (2) tick();
    bus.out_ready = 1'b1;
    drain();

    // Asynchronous reset with both stages full
    bus.out_ready = 1'b0;
    send(32'h11, 32'h22, 1'b0, mk(32'h33, 1'b0, 1'b0, 1'b0));
    send(32'h44, 32'h11, 1'b1, mk(32'h33, 1'b1, 1'b0, 1'b0));
    idle();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_dout_flags", 64'({bus.dout, bus.carry_out, bus.overflow, bus.zero}), 64'd0);
    sb.delete();
    tick();
    rst = 1'b0;
    #1;
    chk("arst_release_ready", 64'({bus.in_ready, bus.out_valid}), 64'({1'b1, 1'b0}));
    bus.out_ready = 1'b1;
    send(32'h4000_0000, 32'h4000_0000, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0));
    idle();
    chk("arst_lat_cycle1", 64'(bus.out_valid), 64'd0);
    tick();
    chk("arst_lat_cycle2", 64'({bus.out_valid, bus.dout}), 64'({1'b1, 32'h8000_0000}));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
